// File: rtl/fp_pkg.sv
// Shared IEEE single-precision types, classes, flags and constants for the fp_div sequencer.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_QNAN,
        FP_SNAN
    } fp_class_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam int          EXP_BIAS  = 127;
    localparam int          EXP_MAX   = 255;

    function automatic logic [31:0] fp_inf(input logic sign);
        return {sign, 8'hFF, 23'd0};
    endfunction

    function automatic logic [31:0] fp_zero(input logic sign);
        return {sign, 31'd0};
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier; subnormals are treated as zero (DAZ).
module fp_classify (
    input  logic [30:0] x_i,
    output logic [2:0]  class_o
);
    import fp_pkg::*;

    fp_class_e cls;

    always_comb begin
        cls = FP_NORM;
        if (x_i[30:23] == 8'h00) begin
            cls = FP_ZERO;
        end else if (x_i[30:23] == 8'hFF) begin
            if (x_i[22:0] == 23'd0) begin
                cls = FP_INF;
            end else if (x_i[22]) begin
                cls = FP_QNAN;
            end else begin
                cls = FP_SNAN;
            end
        end
    end

    assign class_o = cls;

endmodule

// File: rtl/fp_div_seq.sv
// Valid/ready sequencer around the iterative fp_div core: resolves IEEE special cases
// locally, issues normal pairs to the core, and guards the core with a watchdog.
module fp_div_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] CANON_NAN      = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result_o,
    output logic [4:0]  flags_o,
    output logic        timeout_o,
    output logic        div_start_o,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    input  logic        div_done_i,
    input  logic [31:0] div_r_i
);
    import fp_pkg::*;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StOut  = 2'd2;

    localparam int unsigned   WdW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    logic [1:0]     state_q, state_d;
    logic [31:0]    result_q, result_d;
    fp_flags_t      flags_q, flags_d;
    logic           timeout_q, timeout_d;
    logic           start_q, start_d;
    logic [31:0]    div_a_q, div_a_d;
    logic [31:0]    div_b_q, div_b_d;
    logic [WdW-1:0] wdog_q, wdog_d;

    fp32_t     op_a, op_b;
    logic [2:0] cls_a_raw, cls_b_raw;
    fp_class_e cls_a, cls_b;

    assign op_a = a_i;
    assign op_b = b_i;

    fp_classify u_class_a (
        .x_i     (a_i[30:0]),
        .class_o (cls_a_raw)
    );

    fp_classify u_class_b (
        .x_i     (b_i[30:0]),
        .class_o (cls_b_raw)
    );

    assign cls_a = fp_class_e'(cls_a_raw);
    assign cls_b = fp_class_e'(cls_b_raw);

    // Biased quotient exponent; one less when the mantissa quotient falls below 1.0.
    logic       man_lt;
    logic [9:0] exp_est;
    logic       exp_ovf, exp_unf;

    assign man_lt  = op_a.man < op_b.man;
    assign exp_est = {2'b00, op_a.exp} - {2'b00, op_b.exp} + 10'(EXP_BIAS) - {9'd0, man_lt};
    assign exp_ovf = $signed(exp_est) >= $signed(10'(EXP_MAX));
    assign exp_unf = $signed(exp_est) <= 10'sd0;

    logic        a_nan, b_nan, q_sign;
    logic        spec_hit;
    logic [31:0] spec_res;
    fp_flags_t   spec_flags;

    assign a_nan  = (cls_a == FP_QNAN) || (cls_a == FP_SNAN);
    assign b_nan  = (cls_b == FP_QNAN) || (cls_b == FP_SNAN);
    assign q_sign = op_a.sign ^ op_b.sign;

    always_comb begin
        spec_hit   = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_res      = CANON_NAN;
            spec_flags.nv = (cls_a == FP_SNAN) || (cls_b == FP_SNAN);
        end else if (((cls_a == FP_ZERO) && (cls_b == FP_ZERO)) ||
                     ((cls_a == FP_INF) && (cls_b == FP_INF))) begin
            spec_res      = CANON_NAN;
            spec_flags.nv = 1'b1;
        end else if (cls_a == FP_INF) begin
            spec_res = fp_inf(q_sign);
        end else if (cls_b == FP_ZERO) begin
            spec_res      = fp_inf(q_sign);
            spec_flags.dz = 1'b1;
        end else if ((cls_a == FP_ZERO) || (cls_b == FP_INF)) begin
            spec_res = fp_zero(q_sign);
        end else if (exp_ovf) begin
            spec_res      = fp_inf(q_sign);
            spec_flags.of = 1'b1;
            spec_flags.nx = 1'b1;
        end else if (exp_unf) begin
            spec_res      = fp_zero(q_sign);
            spec_flags.uf = 1'b1;
            spec_flags.nx = 1'b1;
        end else begin
            spec_hit = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flags_d   = flags_q;
        timeout_d = timeout_q;
        start_d   = 1'b0;
        div_a_d   = div_a_q;
        div_b_d   = div_b_q;
        wdog_d    = wdog_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (spec_hit) begin
                        result_d = spec_res;
                        flags_d  = spec_flags;
                        state_d  = StOut;
                    end else begin
                        div_a_d = a_i;
                        div_b_d = b_i;
                        start_d = 1'b1;
                        wdog_d  = '0;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (div_done_i) begin
                    result_d   = div_r_i;
                    flags_d    = '0;
                    flags_d.nx = |div_r_i[22:0];
                    state_d    = StOut;
                end else if (wdog_q == WdLast) begin
                    result_d   = CANON_NAN;
                    flags_d    = '0;
                    flags_d.nv = 1'b1;
                    timeout_d  = 1'b1;
                    state_d    = StOut;
                end else begin
                    wdog_d = wdog_q + WdW'(1);
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            result_q  <= '0;
            flags_q   <= '0;
            timeout_q <= 1'b0;
            start_q   <= 1'b0;
            div_a_q   <= '0;
            div_b_q   <= '0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            timeout_q <= timeout_d;
            start_q   <= start_d;
            div_a_q   <= div_a_d;
            div_b_q   <= div_b_d;
            wdog_q    <= wdog_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StOut);
    assign result_o    = result_q;
    assign flags_o     = flags_q;
    assign timeout_o   = timeout_q;
    assign div_start_o = start_q;
    assign div_a_o     = div_a_q;
    assign div_b_o     = div_b_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq with a fixed-latency stub standing in for the fp_div core.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result_o;
    logic [4:0]  flags_o;
    logic        timeout_o;
    logic        div_start_o;
    logic [31:0] div_a_o;
    logic [31:0] div_b_o;
    logic        stub_done;
    logic [31:0] stub_r = 32'h4000_0000;
    logic        stub_en = 1'b1;
    logic [2:0]  stub_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_div_seq u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_i         (a_in),
        .b_i         (b_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result_o    (result_o),
        .flags_o     (flags_o),
        .timeout_o   (timeout_o),
        .div_start_o (div_start_o),
        .div_a_o     (div_a_o),
        .div_b_o     (div_b_o),
        .div_done_i  (stub_done),
        .div_r_i     (stub_r)
    );

    // Core stub: done is high in the fifth cycle after the start cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stub_cnt  <= '0;
            stub_done <= 1'b0;
        end else begin
            stub_done <= 1'b0;
            if (div_start_o) begin
                stub_cnt <= 3'd1;
            end else if (stub_cnt != 3'd0) begin
                if (stub_cnt == 3'd4) begin
                    stub_cnt  <= '0;
                    stub_done <= stub_en;
                end else begin
                    stub_cnt <= stub_cnt + 3'd1;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;
        int          lat;
        int          starts;
        logic [31:0] a;
        logic        tmo;
        int          acc;
    } sb_t;

    sb_t  sb_q[$];
    logic exp_tmo = 1'b0;
    logic prev_valid = 1'b0;
    int   start_cnt = 0;

    // Reference model: flags are {NV,DZ,OF,UF,NX}.
    function automatic sb_t model(input logic [31:0] a, input logic [31:0] b);
        sb_t  e;
        logic s;
        int   ea, eb, ex;
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [22:0] ma, mb, mr;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = a[22:0];
        mb = b[22:0];
        a_nan  = (ea == 255) && (ma != 0);
        b_nan  = (eb == 255) && (mb != 0);
        a_inf  = (ea == 255) && (ma == 0);
        b_inf  = (eb == 255) && (mb == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        ex = ea - eb + 127 - ((ma < mb) ? 1 : 0);
        e.res = 32'h0; e.flags = 5'b00000; e.lat = 1; e.starts = 0;
        e.a = a; e.tmo = 1'b0; e.acc = 0;
        if (a_nan || b_nan) begin
            e.res = 32'h7FC0_0000;
            if ((a_nan && !ma[22]) || (b_nan && !mb[22])) e.flags = 5'b10000;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            e.res = 32'h7FC0_0000; e.flags = 5'b10000;
        end else if (a_inf) begin
            e.res = s ? 32'hFF80_0000 : 32'h7F80_0000;
        end else if (b_zero) begin
            e.res = s ? 32'hFF80_0000 : 32'h7F80_0000; e.flags = 5'b01000;
        end else if (a_zero || b_inf) begin
            e.res = s ? 32'h8000_0000 : 32'h0;
        end else if (ex >= 255) begin
            e.res = s ? 32'hFF80_0000 : 32'h7F80_0000; e.flags = 5'b00101;
        end else if (ex <= 0) begin
            e.res = s ? 32'h8000_0000 : 32'h0; e.flags = 5'b00011;
        end else if (stub_en) begin
            mr = stub_r[22:0];
            e.res = stub_r; e.flags = (mr != 0) ? 5'b00001 : 5'b00000;
            e.lat = 7; e.starts = 1;
        end else begin
            e.res = 32'h7FC0_0000; e.flags = 5'b10000;
            e.lat = 65; e.starts = 1; e.tmo = 1'b1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        sb_t e;
        if (!reset_n) begin
            prev_valid = 1'b0;
        end else begin
            if (div_start_o) start_cnt++;
            if (out_valid && !prev_valid) begin
                check_eq("out_has_entry", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) check_eq("latency", cyc - sb_q[0].acc, sb_q[0].lat);
            end
            if (out_valid && out_ready) begin
                check_eq("pop_has_entry", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_eq("result", result_o, e.res);
                    check_eq("flags", 32'(flags_o), 32'(e.flags));
                    check_eq("starts", start_cnt, e.starts);
                    check_eq("timeout", 32'(timeout_o), 32'(exp_tmo));
                    if (e.starts != 0) check_eq("div_a", div_a_o, e.a);
                end
            end
            if (in_valid && in_ready) begin
                e = model(a_in, b_in);
                e.acc = cyc;
                sb_q.push_back(e);
                start_cnt = 0;
                if (e.tmo) exp_tmo = 1'b1;
            end
            prev_valid = out_valid;
        end
    end

    task automatic wait_accept();
        logic ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        check_eq("accept", 32'(ok), 32'd1);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        a_in = a; b_in = b; in_valid = 1'b1;
        wait_accept();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", sb_q.size(), 0);
    endtask

    task automatic check_reset_outs();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", result_o, 32'd0);
        check_eq("rst_flags", 32'(flags_o), 32'd0);
        check_eq("rst_timeout", 32'(timeout_o), 32'd0);
        check_eq("rst_start", 32'(div_start_o), 32'd0);
        check_eq("rst_div_a", div_a_o, 32'd0);
        check_eq("rst_div_b", div_b_o, 32'd0);
    endtask

    logic [31:0] ops_a[15] = '{32'h40C0_0000, 32'h0000_0000, 32'h3F80_0000, 32'h7F00_0000,
                               32'h0080_0000, 32'h7FC0_0001, 32'h3F80_0000, 32'h7F80_0000,
                               32'hFF80_0000, 32'h0000_0000, 32'hBF80_0000, 32'h0000_0001,
                               32'h7F00_0000, 32'h0080_0000, 32'h7F00_0000};
    logic [31:0] ops_b[15] = '{32'h4040_0000, 32'h0000_0000, 32'h8000_0000, 32'h0080_0000,
                               32'h7F00_0000, 32'h3F80_0000, 32'h7F80_0001, 32'hFF80_0000,
                               32'h4000_0000, 32'hC000_0000, 32'h7F80_0000, 32'h3F80_0000,
                               32'h3F00_0000, 32'h4000_0000, 32'h3F80_0000};

    initial begin
        repeat (3) @(posedge clk);
        #1 check_reset_outs();
        @(negedge clk) reset_n = 1'b1;
        #1 check_eq("ready_after_rst", 32'(in_ready), 32'd1);

        // Directed table: normal, special, and exponent-boundary pairs.
        for (int i = 0; i < 15; i++) begin
            stub_r = (i == 0) ? 32'h4000_0000 : 32'h3F80_0000 + 32'(i);
            issue(ops_a[i], ops_b[i]);
            drain();
        end
        stub_r = 32'h3FC0_0001;
        issue(32'h0080_0000, 32'h3F80_0000);
        drain();

        // Core never answers: watchdog fires, timeout stays sticky.
        stub_en = 1'b0;
        issue(32'h40C0_0000, 32'h4040_0000);
        drain();
        stub_en = 1'b1;
        issue(32'h0000_0000, 32'h0000_0000);
        drain();
        check_eq("timeout_sticky", 32'(timeout_o), 32'd1);

        // Backpressure: result held and input blocked while out_ready is low.
        out_ready = 1'b0;
        @(posedge clk); #1;
        a_in = 32'h0000_0000; b_in = 32'h0000_0000; in_valid = 1'b1;
        wait_accept();
        @(posedge clk); #1;
        a_in = 32'h3F80_0000; b_in = 32'h8000_0000;
        @(negedge clk);
        check_eq("bp_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_eq("bp_result", result_o, 32'h7FC0_0000);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        drain();

        // Reset in the middle of a core operation.
        stub_r = 32'h4000_0000;
        issue(32'h40C0_0000, 32'h4040_0000);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_reset_outs();
        sb_q.delete();
        exp_tmo = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        #1 check_eq("ready_after_rst2", 32'(in_ready), 32'd1);
        issue(32'h40C0_0000, 32'h4040_0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
